// File: rtl/stage_fetch.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// stage_fetch
//
// Instruction-fetch stage of the 5-stage core. It owns the PC register,
// talks to a variable-latency instruction memory through a request/ready
// handshake, and produces the IF/ID pipeline register read by decode.
//
// Ports
//   clk           core clock, all state changes on the rising edge
//   rst           synchronous active-high reset
//   de_stall      hazard unit: hold IF/ID and PC
//   de_clear      hazard unit: flush IF/ID to NOP
//   ex_pc_src     execute stage: branch/jump redirect taken this cycle
//   ex_pc_target  redirect target (low two bits are ignored)
//   imem_req      instruction read request
//   imem_addr     word-aligned read address, stable until imem_ready
//   imem_ready    memory completes the request this cycle
//   imem_rdata    instruction word, valid with imem_ready
//   de_instr      IF/ID: instruction
//   de_pc         IF/ID: PC of de_instr
//   de_pc_plus4   IF/ID: de_pc + 4
//
// States
//   FETCH    a request for pc is outstanding
//   HOLD     the word arrived while decode was stalled/cleared; it is kept
//            in the hold buffer and no request is issued
//   DISCARD  a redirect happened while a request was in flight; the memory
//            cannot abort it, so the old address stays on the bus and the
//            returning word is thrown away
// ----------------------------------------------------------------------------
module stage_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        de_stall,
   input  logic        de_clear,
   input  logic        ex_pc_src,
   input  logic [31:0] ex_pc_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] de_instr,
   output logic [31:0] de_pc,
   output logic [31:0] de_pc_plus4
);

   typedef enum logic [1:0] {
      S_FETCH   = 2'd0,
      S_HOLD    = 2'd1,
      S_DISCARD = 2'd2
   } state_t;

   localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

   state_t      state_reg;
   logic [31:0] pc_reg;
   logic [31:0] discard_addr_reg;   // address of the in-flight stale request
   logic [31:0] hold_buf_reg;       // word captured while decode was blocked
   logic [31:0] de_instr_reg;
   logic [31:0] de_pc_reg;
   logic [31:0] de_pc_plus4_reg;

   logic [31:0] pc_plus4;
   logic [31:0] redirect_pc;
   logic        decode_blocked;

   // Wraps naturally modulo 2^32.
   assign pc_plus4    = pc_reg + 32'd4;
   assign redirect_pc = ex_pc_target & ALIGN_MASK;

   // Either hazard signal keeps the fetch side from advancing; de_clear
   // additionally forces a NOP into IF/ID.
   assign decode_blocked = de_stall | de_clear;

   // The request is suppressed combinationally during reset so that no
   // read is issued in a cycle where rst is high, even mid-request.
   assign imem_req  = ~rst & (state_reg != S_HOLD);
   assign imem_addr = (state_reg == S_DISCARD) ? discard_addr_reg : pc_reg;

   assign de_instr    = de_instr_reg;
   assign de_pc       = de_pc_reg;
   assign de_pc_plus4 = de_pc_plus4_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg        <= S_FETCH;
         pc_reg           <= RESET_PC & ALIGN_MASK;
         discard_addr_reg <= 32'd0;
         hold_buf_reg     <= 32'd0;
         de_instr_reg     <= NOP_INSTR;
         de_pc_reg        <= 32'd0;
         de_pc_plus4_reg  <= 32'd0;
      end else begin
         case (state_reg)
            S_FETCH: begin
               if (ex_pc_src) begin
                  pc_reg          <= redirect_pc;
                  de_instr_reg    <= NOP_INSTR;
                  de_pc_reg       <= 32'd0;
                  de_pc_plus4_reg <= 32'd0;
                  // A completed word is simply dropped; an unfinished
                  // request must be allowed to drain at its old address.
                  if (!imem_ready) begin
                     discard_addr_reg <= pc_reg;
                     state_reg        <= S_DISCARD;
                  end
               end else if (imem_ready) begin
                  if (decode_blocked) begin
                     hold_buf_reg <= imem_rdata;
                     state_reg    <= S_HOLD;
                     if (de_clear) begin
                        de_instr_reg <= NOP_INSTR;
                     end
                  end else begin
                     de_instr_reg    <= imem_rdata;
                     de_pc_reg       <= pc_reg;
                     de_pc_plus4_reg <= pc_plus4;
                     pc_reg          <= pc_plus4;
                  end
               end else begin
                  // Memory is slow: bubble into decode unless decode holds.
                  // The pc fields are left as they were.
                  if (de_clear || !de_stall) begin
                     de_instr_reg <= NOP_INSTR;
                  end
               end
            end

            S_HOLD: begin
               if (ex_pc_src) begin
                  pc_reg          <= redirect_pc;
                  de_instr_reg    <= NOP_INSTR;
                  de_pc_reg       <= 32'd0;
                  de_pc_plus4_reg <= 32'd0;
                  state_reg       <= S_FETCH;
               end else if (de_clear) begin
                  // The buffered word is the next instruction, not the one
                  // being flushed, so it is kept.
                  de_instr_reg <= NOP_INSTR;
               end else if (!de_stall) begin
                  de_instr_reg    <= hold_buf_reg;
                  de_pc_reg       <= pc_reg;
                  de_pc_plus4_reg <= pc_plus4;
                  pc_reg          <= pc_plus4;
                  state_reg       <= S_FETCH;
               end
            end

            S_DISCARD: begin
               // IF/ID already holds the redirect NOP and stays that way.
               if (ex_pc_src) begin
                  pc_reg          <= redirect_pc;
                  de_instr_reg    <= NOP_INSTR;
                  de_pc_reg       <= 32'd0;
                  de_pc_plus4_reg <= 32'd0;
               end
               // Once the stale request completes, the next request goes
               // out at pc (the newest redirect target). This also covers a
               // second redirect landing in the completion cycle.
               if (imem_ready) begin
                  state_reg <= S_FETCH;
               end
            end

            default: begin
               state_reg <= S_FETCH;
            end
         endcase
      end
   end

endmodule
